wi_weight_loader: RTL and testbench
===================================

// Module: wi_weight_loader
// PURPOSE
//  Write-side counterpart of the weight ROM read path: accepts framed weight bytes over a
//  valid/ready byte stream and writes them into a 256x8 weight store.
//  It also serves neuron-side reads via an add/Wip port with the same meaning as the ROM's.
//  Sits between the host/UART byte link and the neuron datapath, so trained weights are
//  loadable at run time instead of hard-coded.
// PARAMETERS
//  AW    8      address width; store depth = 2**AW
//  DW    8      weight/data width
//  SYNC  8'hA5  frame start byte
// PORTS
//  CS        in   1   clock; all state updates on posedge CS
//  rst       in   1   asynchronous, active-high reset
//  in_valid  in   1   input byte valid
//  in_data   in   DW  input byte
//  in_ready  out  1   loader accepts in_data this cycle (transfer = in_valid & in_ready)
//  rd_en     in   1   neuron-side read strobe
//  add       in   AW  neuron-side read address
//  Wip       out  DW  read data, registered
//  busy      out  1   frame in progress (state != IDLE)
//  done      out  1   one-cycle pulse: frame fully written
//  err       out  1   sticky: a non-SYNC byte was dropped in IDLE; cleared by rst or next accepted SYNC
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-high. Reset forces state=IDLE, Wip=0,
//   busy=0, done=0, err=0, in_ready=0 while rst is high, counters=0. Store contents are NOT cleared.
//  Frame format: SYNC, base[AW-1:0], len_m1[AW-1:0], then N = len_m1+1 data bytes (N = 1..256).
//  FSM states (IDLE, HADDR, HLEN, LOAD, DONE); all transitions occur on accepted transfers only:
//   IDLE  -> HADDR on SYNC; any other byte is dropped and sets err.
//   HADDR -> HLEN; latch base.
//   HLEN  -> LOAD; latch cnt = len_m1, ptr = base.
//   LOAD  -> writes store[ptr] = in_data; ptr = ptr+1 mod 2**AW (wraps 255->0);
//            cnt==0 on this transfer -> DONE, else cnt = cnt-1.
//   DONE  -> IDLE unconditionally after 1 cycle; done=1 only in this cycle.
//  in_ready: 1 in IDLE/HADDR/HLEN/LOAD, 0 in DONE and during reset. No backpressure otherwise.
//  Sequence: N data bytes take exactly N accepted transfers; a byte equal to SYNC inside a
//   frame is data, with no resync. in_valid gaps stall the FSM without timeout.
//  Write latency: a byte accepted at edge k is visible to a read issued at edge k+1 or later.
//  Read port: on posedge with rd_en=1, Wip <= store[add] (1-cycle latency); rd_en=0 holds Wip.
//   Same-cycle read and write to the same address returns OLD data (read-first).
//   Reads are legal in every state, including mid-frame.
//  Reset mid-frame: frame abandoned; bytes already written remain; no done pulse.
//  busy = 1 in HADDR/HLEN/LOAD/DONE.
// STRUCTURE
//  Shared package wi_pkg: state enum wi_ld_state_t, constants WI_SYNC, WI_AW, WI_DW.
//  Sub-module wi_ram: simple dual-port synchronous RAM (1W + 1R, read-first, registered
//   read, no reset on array). The top level holds the FSM, base/ptr/cnt registers and flags.
// TESTING
//  1 Reset then idle: after rst deassert -> Wip=0, busy=0, done=0, err=0, in_ready=1.
//  2 Frame A5,10,03,11,22,33,44 -> done pulses 1 cycle after byte 44; reads of add 10..13
//    return 11,22,33,44 with 1-cycle latency; add 14 unchanged.
//  3 Wrap: A5,FE,02,AA,BB,CC -> store[FE]=AA, [FF]=BB, [00]=CC; done once.
//  4 Full 256: A5,00,FF, then bytes 0..255 with random in_valid gaps -> store[i]=i for all i;
//    exactly 256 writes; in_ready=0 only in the DONE cycle.
//  5 Junk + collision: 5A in IDLE -> err=1, state IDLE; then A5 -> err=0. Writing 77 to 20
//    while rd_en,add=20 -> Wip=old value; next read -> 77.
//  6 Reset mid-LOAD after 2 of 4 bytes -> no done; first 2 bytes stored; rest untouched;
//    next frame loads normally.

Source files
------------

// File: rtl/wi_pkg.sv
// Shared definitions for the weight loader: loader FSM states and
// default widths / frame start byte.
package wi_pkg;

    localparam int         WI_AW   = 8;
    localparam int         WI_DW   = 8;
    localparam logic [7:0] WI_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HADDR = 3'd1,
        ST_HLEN  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } wi_ld_state_t;

endpackage

// File: rtl/wi_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Ports: clk, rst (clears only the read register), we/waddr/wdata (write),
//        re/raddr (read strobe/address), rdata (registered read data).
module wi_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Array has no reset so trained weights survive a loader reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the array gives read-first on a same-address
    // collision: the old word is captured before the write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wi_weight_loader.sv
// Framed byte-stream loader into a 256x8 weight store, plus neuron read port.
// Ports: CS clock, rst async high; in_valid/in_data/in_ready byte stream;
//        rd_en/add/Wip read port; busy, done (pulse), err (sticky junk flag).
import wi_pkg::*;

module wi_weight_loader #(
    parameter int            AW   = WI_AW,
    parameter int            DW   = WI_DW,
    parameter logic [DW-1:0] SYNC = WI_SYNC
) (
    input  logic          CS,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] add,
    output logic [DW-1:0] Wip,
    output logic          busy,
    output logic          done,
    output logic          err
);

    wi_ld_state_t  state;
    wi_ld_state_t  state_nxt;
    logic [AW-1:0] base;
    logic [AW-1:0] ptr;
    logic [AW-1:0] cnt;
    logic          fire;
    logic          we;
    logic          is_sync;

    // Ready is combinational on rst so no byte is taken while held in reset.
    assign in_ready = ~rst & (state != ST_DONE);
    assign fire     = in_valid & in_ready;
    assign is_sync  = (in_data == SYNC);
    assign we       = fire & (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge CS or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (fire && is_sync) begin
                    state_nxt = ST_HADDR;
                end
            end
            ST_HADDR: begin
                if (fire) begin
                    state_nxt = ST_HLEN;
                end
            end
            ST_HLEN: begin
                if (fire) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (fire && (cnt == '0)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CS or posedge rst) begin
        if (rst) begin
            base <= '0;
            ptr  <= '0;
            cnt  <= '0;
        end else if (fire) begin
            if (state == ST_HADDR) begin
                base <= in_data[AW-1:0];
            end
            if (state == ST_HLEN) begin
                cnt <= in_data[AW-1:0];
                ptr <= base;
            end
            if (state == ST_LOAD) begin
                // Natural AW-bit overflow gives the 255 -> 0 wrap.
                ptr <= ptr + 1'b1;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // Junk in IDLE sets err; the next accepted SYNC clears it.
    always_ff @(posedge CS or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (fire && (state == ST_IDLE)) begin
            err <= ~is_sync;
        end
    end

    wi_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk  (CS),
        .rst  (rst),
        .we   (we),
        .waddr(ptr),
        .wdata(in_data),
        .re   (rd_en),
        .raddr(add),
        .rdata(Wip)
    );

endmodule

// File: tb/tb_wi_weight_loader.sv
// Scoreboard bench for wi_weight_loader: drives framed byte streams,
// keeps a model of the store and checks reads, flags and handshake.
module tb_wi_weight_loader;

    logic       CS;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       rd_en;
    logic [7:0] add;
    logic [7:0] Wip;
    logic       busy;
    logic       done;
    logic       err;

    int checks;
    int failures;
    int done_cnt;
    int nrdy_cnt;

    logic [7:0] mdl [256];
    logic [7:0] exp_q [$];

    wi_weight_loader dut (
        .CS      (CS),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .rd_en   (rd_en),
        .add     (add),
        .Wip     (Wip),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial CS = 1'b0;
    always #5 CS = ~CS;

    always @(negedge CS) begin
        if (!rst && done) done_cnt++;
        if (!rst && !in_ready) nrdy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) @(negedge CS);
        @(negedge CS);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge CS);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 0, 1);
        @(posedge CS);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base,
                              input logic [7:0] data [$], input bit gaps);
        logic [7:0] a;
        send_byte(8'hA5, 0);
        send_byte(base, 0);
        send_byte(8'(data.size() - 1), 0);
        a = base;
        foreach (data[i]) begin
            send_byte(data[i], gaps ? int'($urandom_range(0, 2)) : 0);
            mdl[a] = data[i];
            a = a + 8'd1;
        end
    endtask

    // Checks the DONE cycle and the return to IDLE after the last data byte.
    task automatic finish_frame(input string tag);
        @(negedge CS);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_rdy_in_done"}, in_ready, 0);
        @(negedge CS);
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    // Back-to-back reads: each result is checked one edge after its request.
    task automatic read_burst(input logic [7:0] start, input int n);
        logic [7:0] e;
        for (int i = 0; i <= n; i++) begin
            @(negedge CS);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data", Wip, e);
            end
            if (i < n) begin
                rd_en = 1'b1;
                add   = start + 8'(i);
                exp_q.push_back(mdl[add]);
            end else begin
                rd_en = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] d [$];
        logic [7:0] e;
        int dc0;

        checks   = 0;
        failures = 0;
        done_cnt = 0;
        nrdy_cnt = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_en    = 1'b0;
        add      = 8'h00;

        repeat (3) @(negedge CS);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge CS);
        chk("rst_wip", Wip, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready_idle", in_ready, 1);

        // Full 256-byte load with gaps
        d = {};
        for (int i = 0; i < 256; i++) d.push_back(8'(i));
        dc0 = done_cnt;
        nrdy_cnt = 0;
        send_frame(8'h00, d, 1'b1);
        chk("full_busy", busy, 1);
        finish_frame("full");
        chk("full_done_once", done_cnt - dc0, 1);
        chk("full_nrdy_once", nrdy_cnt, 1);
        read_burst(8'h00, 256);

        // Frame A
        dc0 = done_cnt;
        send_frame(8'h10, '{8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
        finish_frame("fa");
        chk("fa_done_once", done_cnt - dc0, 1);
        read_burst(8'h10, 5);
        @(negedge CS);
        chk("rd_hold", Wip, mdl[8'h14]);

        // Wrap across 0xFF
        dc0 = done_cnt;
        send_frame(8'hFE, '{8'hAA, 8'hBB, 8'hCC}, 1'b0);
        finish_frame("wrap");
        chk("wrap_done_once", done_cnt - dc0, 1);
        read_burst(8'hFD, 5);

        // Junk then SYNC, then read/write collision
        send_byte(8'h5A, 0);
        @(negedge CS);
        chk("junk_err", err, 1);
        chk("junk_idle", busy, 0);
        send_byte(8'hA5, 0);
        @(negedge CS);
        chk("sync_err_clr", err, 0);
        chk("sync_busy", busy, 1);
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        @(negedge CS);
        in_valid = 1'b1;
        in_data  = 8'h77;
        rd_en    = 1'b1;
        add      = 8'h20;
        chk("col_ready", in_ready, 1);
        exp_q.push_back(mdl[8'h20]);
        @(posedge CS);
        #1;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        e = exp_q.pop_front();
        chk("col_old", Wip, e);
        mdl[8'h20] = 8'h77;
        finish_frame("col");
        read_burst(8'h20, 1);

        // Reset in the middle of a 4-byte load
        dc0 = done_cnt;
        send_byte(8'hA5, 0);
        send_byte(8'h40, 0);
        send_byte(8'h03, 0);
        send_byte(8'hD1, 0);
        send_byte(8'hD2, 0);
        mdl[8'h40] = 8'hD1;
        mdl[8'h41] = 8'hD2;
        @(negedge CS);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_wip", Wip, 0);
        @(negedge CS);
        rst = 1'b0;
        repeat (2) @(negedge CS);
        chk("mid_no_done", done_cnt - dc0, 0);
        chk("mid_idle", busy, 0);
        read_burst(8'h40, 4);
        send_frame(8'h42, '{8'hE1, 8'hE2}, 1'b0);
        finish_frame("post");
        read_burst(8'h40, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
